// File: rtl/matmul_scheduler.sv
// matmul_scheduler: sequences clear, operand feed/shift, optional bias read and write-back for the systolic array.
module matmul_scheduler #(
  parameter int MAX_DIM     = 4,
  parameter int SP_NTARGETS = 4,
  parameter int DIM_W       = $clog2(MAX_DIM) + 1,
  parameter int SPT_W       = $clog2(SP_NTARGETS),
  parameter int CNT_W       = $clog2(3 * MAX_DIM)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] n_dim_i,
  input  logic [DIM_W-1:0] k_dim_i,
  input  logic [DIM_W-1:0] m_dim_i,
  input  logic             bias_en_i,
  input  logic [SPT_W-1:0] rd_target_i,
  input  logic [SPT_W-1:0] wr_target_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             array_clear_o,
  output logic             array_shift_en_o,
  output logic             op_rd_en_o,
  output logic [DIM_W-1:0] op_idx_o,
  output logic             sp_rd_en_o,
  output logic [SPT_W-1:0] sp_rd_target_o,
  output logic             sp_wr_en_o,
  output logic [SPT_W-1:0] sp_wr_target_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, COMPUTE, BIAS, WRITE, DONE, REJECT} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] s_q, last_q;
  logic [DIM_W-1:0] k_q;
  logic             bias_q;
  logic [SPT_W-1:0] rd_q, wr_q;
  logic             bad_dims;
  assign bad_dims = (n_dim_i == '0) || (n_dim_i > DIM_W'(MAX_DIM)) ||
                    (k_dim_i == '0) || (k_dim_i > DIM_W'(MAX_DIM)) ||
                    (m_dim_i == '0) || (m_dim_i > DIM_W'(MAX_DIM));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      last_q  <= '0;
      k_q     <= '0;
      bias_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          k_q     <= k_dim_i;
          bias_q  <= bias_en_i;
          rd_q    <= rd_target_i;
          wr_q    <= wr_target_i;
          // index of the final compute step: K+N+M-2 steps, counted from 0
          last_q  <= CNT_W'(n_dim_i) + CNT_W'(k_dim_i) + CNT_W'(m_dim_i) - CNT_W'(3);
          state_q <= bad_dims ? REJECT : CLEAR;
        end
        CLEAR: begin
          s_q     <= '0;
          state_q <= COMPUTE;
        end
        COMPUTE: if (!stall_i) begin
          s_q <= s_q + CNT_W'(1);
          if (s_q == last_q) state_q <= bias_q ? BIAS : WRITE;
        end
        BIAS:    state_q <= WRITE;
        WRITE:   state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o           = (state_q == CLEAR) || (state_q == COMPUTE) || (state_q == BIAS) || (state_q == WRITE);
  assign done_o           = (state_q == DONE) || (state_q == REJECT);
  assign err_o            = state_q == REJECT;
  assign array_clear_o    = state_q == CLEAR;
  assign array_shift_en_o = (state_q == COMPUTE) && !stall_i;
  // past column K the array is fed zeros while the skew drains
  assign op_rd_en_o       = array_shift_en_o && (s_q < CNT_W'(k_q));
  assign op_idx_o         = op_rd_en_o ? DIM_W'(s_q) : '0;
  assign sp_rd_en_o       = state_q == BIAS;
  assign sp_rd_target_o   = sp_rd_en_o ? rd_q : '0;
  assign sp_wr_en_o       = state_q == WRITE;
  assign sp_wr_target_o   = sp_wr_en_o ? wr_q : '0;
endmodule

// File: tb/tb_matmul_scheduler.sv
// tb_matmul_scheduler: directed cycle-by-cycle checks of the matmul scheduler against hand-derived timelines.
module tb_matmul_scheduler;
  logic       clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, bias_en_i = 1'b0, stall_i = 1'b0;
  logic [2:0] n_dim_i = '0, k_dim_i = '0, m_dim_i = '0;
  logic [1:0] rd_target_i = '0, wr_target_i = '0;
  logic       busy_o, done_o, err_o, array_clear_o, array_shift_en_o, op_rd_en_o, sp_rd_en_o, sp_wr_en_o;
  logic [2:0] op_idx_o;
  logic [1:0] sp_rd_target_o, sp_wr_target_o;
  int         checks = 0, errors = 0;
  logic [14:0] obs;

  matmul_scheduler dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .n_dim_i(n_dim_i), .k_dim_i(k_dim_i),
    .m_dim_i(m_dim_i), .bias_en_i(bias_en_i), .rd_target_i(rd_target_i), .wr_target_i(wr_target_i),
    .stall_i(stall_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .array_clear_o(array_clear_o),
    .array_shift_en_o(array_shift_en_o), .op_rd_en_o(op_rd_en_o), .op_idx_o(op_idx_o),
    .sp_rd_en_o(sp_rd_en_o), .sp_rd_target_o(sp_rd_target_o), .sp_wr_en_o(sp_wr_en_o),
    .sp_wr_target_o(sp_wr_target_o)
  );

  always #5 clk = ~clk;

  assign obs = {busy_o, done_o, err_o, array_clear_o, array_shift_en_o, op_rd_en_o, op_idx_o,
                sp_rd_en_o, sp_rd_target_o, sp_wr_en_o, sp_wr_target_o};

  function automatic logic [14:0] ev(input logic busy, done, err, clr, sh, rd, input logic [2:0] idx,
                                     input logic sr, input logic [1:0] srt, input logic sw, input logic [1:0] swt);
    return {busy, done, err, clr, sh, rd, idx, sr, srt, sw, swt};
  endfunction

  task automatic chk(input string tag, input int c, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  // advance one cycle; command inputs go to junk that would be rejected if wrongly latched
  task automatic step(input logic st, input logic sv);
    @(posedge clk);
    #1;
    stall_i = st; start_i = sv;
    n_dim_i = 3'd0; k_dim_i = 3'd0; m_dim_i = 3'd0; bias_en_i = 1'b1; rd_target_i = 2'd1; wr_target_i = 2'd0;
    #1;
  endtask

  task automatic cmd(input logic [2:0] n, k, m, input logic b, input logic [1:0] rt, wt);
    n_dim_i = n; k_dim_i = k; m_dim_i = m; bias_en_i = b; rd_target_i = rt; wr_target_i = wt;
    start_i = 1'b1;
  endtask

  task automatic chk_basic(input string tag, input int c);
    chk(tag, c, ev(c >= 1 && c <= 6, c == 7, 1'b0, c == 1, c >= 2 && c <= 5, c == 2 || c == 3,
                   (c == 3) ? 3'd1 : 3'd0, 1'b0, 2'd0, c == 6, (c == 6) ? 2'd3 : 2'd0));
  endtask

  initial begin
    #3;
    chk("reset", 0, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    chk("idle", 0, '0);

    cmd(3'd2, 3'd2, 3'd2, 1'b0, 2'd0, 2'd3);
    for (int c = 1; c <= 8; c++) begin step(1'b0, 1'b0); chk_basic("basic", c); end

    cmd(3'd4, 3'd3, 3'd1, 1'b1, 2'd2, 2'd1);
    for (int c = 1; c <= 11; c++) begin
      step(1'b0, 1'b0);
      chk("bias", c, ev(c >= 1 && c <= 9, c == 10, 1'b0, c == 1, c >= 2 && c <= 7, c >= 2 && c <= 4,
                        (c >= 2 && c <= 4) ? 3'(c - 2) : 3'd0, c == 8, (c == 8) ? 2'd2 : 2'd0,
                        c == 9, (c == 9) ? 2'd1 : 2'd0));
    end

    cmd(3'd2, 3'd2, 3'd2, 1'b0, 2'd0, 2'd3);
    for (int c = 1; c <= 10; c++) begin
      step(c == 3 || c == 4, 1'b0);
      chk("stall", c, ev(c >= 1 && c <= 8, c == 9, 1'b0, c == 1, c == 2 || (c >= 5 && c <= 7), c == 2 || c == 5,
                         (c == 5) ? 3'd1 : 3'd0, 1'b0, 2'd0, c == 8, (c == 8) ? 2'd3 : 2'd0));
    end

    cmd(3'd2, 3'd0, 3'd2, 1'b0, 2'd0, 2'd3);
    step(1'b0, 1'b0); chk("rej_k0", 1, ev(0, 1, 1, 0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0));
    step(1'b0, 1'b0); chk("rej_k0", 2, '0);
    cmd(3'd2, 3'd2, 3'd5, 1'b1, 2'd1, 2'd2);
    step(1'b0, 1'b0); chk("rej_m5", 1, ev(0, 1, 1, 0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0));
    step(1'b0, 1'b0); chk("rej_m5", 2, '0);

    cmd(3'd2, 3'd2, 3'd2, 1'b0, 2'd0, 2'd3);
    for (int c = 1; c <= 8; c++) begin step(1'b0, c == 3 || c == 7); chk_basic("ign_start", c); end
    cmd(3'd2, 3'd2, 3'd2, 1'b0, 2'd0, 2'd3);
    for (int c = 1; c <= 8; c++) begin step(1'b0, 1'b0); chk_basic("restart", c); end

    cmd(3'd2, 3'd2, 3'd2, 1'b0, 2'd0, 2'd3);
    for (int c = 1; c <= 4; c++) begin step(1'b0, 1'b0); chk_basic("pre_rst", c); end
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async", 4, '0);
    @(posedge clk); #1;
    chk("rst_hold", 5, '0);
    rst_i = 1'b0;
    for (int c = 6; c <= 9; c++) begin step(1'b0, 1'b0); chk("rst_quiet", c, '0); end
    cmd(3'd2, 3'd2, 3'd2, 1'b0, 2'd0, 2'd3);
    for (int c = 1; c <= 8; c++) begin step(1'b0, 1'b0); chk_basic("post_rst", c); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matmul_scheduler.md
Name: matmul_scheduler

Overview:
- Sequencing controller for the matmul systolic-array datapath.
- Accepts a start command carrying the operand dimensions N×K · K×M, a bias mode and scratchpad targets.
- Steps the array through clear, operand feed/shift, optional bias read and result write-back, then pulses done.
- Sits between the bus/register front end and the array + scratchpad.

Parameters:
- MAX_DIM, 4, maximum matrix dimension; each of N, K, M must lie in 1..MAX_DIM.
- SP_NTARGETS, 4, number of scratchpad result slots.
- DIM_W, $clog2(MAX_DIM)+1, width of the dimension fields.
- SPT_W, $clog2(SP_NTARGETS), width of a scratchpad target index.
- CNT_W, $clog2(3*MAX_DIM), width of the internal step counter.

Ports:
- clk_i  in  1  the single clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle command pulse.
- n_dim_i  in  DIM_W  rows of A.
- k_dim_i  in  DIM_W  shared dimension.
- m_dim_i  in  DIM_W  columns of B.
- bias_en_i  in  1  when 1, add the scratchpad contents at rd_target_i as bias.
- rd_target_i  in  SPT_W  bias source slot.
- wr_target_i  in  SPT_W  result destination slot.
- stall_i  in  1  operand memory not ready; freezes the compute step.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid only with done_o; 1 = command rejected.
- array_clear_o  out  1  clear the array accumulators.
- array_shift_en_o  out  1  advance the systolic array one step.
- op_rd_en_o  out  1  read operand slice.
- op_idx_o  out  DIM_W  operand index: column of A / row of B.
- sp_rd_en_o  out  1  scratchpad bias read.
- sp_rd_target_o  out  SPT_W  scratchpad read slot.
- sp_wr_en_o  out  1  scratchpad result write.
- sp_wr_target_o  out  SPT_W  scratchpad write slot.

Behaviour:
- Reset and clocking: one clock, clk_i. Reset rst_i is asynchronous and active-high. While reset is asserted, every output is 0 and the FSM is in IDLE. Reset asserted mid-command aborts it immediately: no done_o and no sp_wr_en_o.
- States: IDLE, CLEAR, COMPUTE, BIAS, WRITE, DONE, REJECT.
- IDLE:
  - start_i is sampled here only.
  - All command inputs are latched on the start cycle. Later input changes have no effect on the running command.
  - If any dimension is 0 or > MAX_DIM, go to REJECT. Otherwise go to CLEAR.
- REJECT: done_o=1, err_o=1 for one cycle, no datapath strobes, then IDLE.
- CLEAR: array_clear_o=1 for one cycle, then COMPUTE. Step counter s is set to 0.
- COMPUTE:
  - Runs T = K+N+M-2 effective steps.
  - On each non-stalled cycle: array_shift_en_o=1 and s increments.
  - While s<K: op_rd_en_o=1 and op_idx_o=s. For s≥K, op_rd_en_o=0 and op_idx_o=0 (zero-feed for skew drain).
  - stall_i=1: shift_en and op_rd_en are 0 and s holds. Any stall length is allowed.
  - The cycle that completes step T-1 goes to BIAS if bias_en was latched, else WRITE.
- BIAS: sp_rd_en_o=1 and sp_rd_target_o=latched rd_target for one cycle, then WRITE.
- WRITE: sp_wr_en_o=1 and sp_wr_target_o=latched wr_target for one cycle, then DONE.
- DONE: done_o=1 and err_o=0 for one cycle, then IDLE.
- busy_o: 1 in CLEAR, COMPUTE, BIAS and WRITE; 0 in IDLE, DONE and REJECT.
- Target outputs read 0 outside their strobe cycle.
- start_i during any non-IDLE state is ignored and not queued. This includes start_i in the DONE cycle.
- start_i is accepted again in the cycle after done_o.
- Latency from the start sample cycle c0, with no stall: CLEAR at c0+1, COMPUTE c0+2..c0+T+1, optional BIAS, WRITE, then DONE.
- Total latency with no stall: T+3 cycles, or T+4 with bias. Each stalled cycle adds exactly 1.
- Minimum case N=K=M=1: T=1, a single compute cycle with op_idx=0.

Test Plan:
- Basic command: N=K=M=2, bias off, wr_target=3, start at cycle 0 -> clear @1; shift @2-5; op_rd_en @2-3 with idx 0,1; sp_wr_en @6 with target 3; done_o @7 with err_o=0; busy_o high 1-6.
- Bias path: N=4, K=3, M=1, bias on, rd_target=2 -> T=6; compute @2-7; op_rd_en @2-4; sp_rd_en @8 with target 2; sp_wr_en @9; done @10.
- Stall: same as the basic command, with stall_i=1 during cycles 3-4 -> no shift @3-4; idx 1 issued @5; shifts @2, 5, 6, 7; write @8; done @9; total 2 cycles later.
- Illegal dims: start with k_dim=0, then separately with m_dim=5 (MAX_DIM=4) -> done_o=1 and err_o=1 the next cycle; no clear, shift or sp strobes; busy_o stays 0.
- Ignored start: start_i pulsed at cycles 3 and 7 (the DONE cycle) of the basic command -> single done at 7; IDLE at 8; a start at 8 runs normally, with clear @9.
- Reset mid-op: rst_i asserted asynchronously at cycle 4 of the basic command -> all outputs 0 immediately; no done/write; after release, a new command behaves as in the basic scenario.
